// File: rtl/adc_pair_realign.sv
// adc_pair_realign: queues ADC channels A and B separately and emits time-aligned (A, B) pairs
// with backpressure, overflow/skew detection and a one-cycle resynchronising flush.
module adc_pair_realign #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 8,
    parameter int MAX_SKEW    = 4,
    parameter bit AUTO_RESYNC = 1'b1
) (
    input  logic                             alg_clk,
    input  logic                             alg_rst,
    input  logic [DATA_W-1:0]                data_in_A_channel,
    input  logic                             data_in_A_channel_en,
    input  logic [DATA_W-1:0]                data_in_B_channel,
    input  logic                             data_in_B_channel_en,
    input  logic                             resync_req,
    input  logic                             clr_status,
    input  logic                             pair_ready,
    output logic [DATA_W-1:0]                pair_A,
    output logic [DATA_W-1:0]                pair_B,
    output logic                             pair_valid,
    output logic                             overflow_A,
    output logic                             overflow_B,
    output logic                             skew_err,
    output logic signed [$clog2(DEPTH)+1:0]  skew,
    output logic [31:0]                      pair_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = AW + 2;
    typedef enum logic {RUN, FLUSH} state_t;
    state_t state_q, state_d;
    logic [DATA_W-1:0] mem_a_q [DEPTH];
    logic [DATA_W-1:0] mem_b_q [DEPTH];
    logic [AW-1:0] wp_a_q, wp_a_d, rp_a_q, rp_a_d, wp_b_q, wp_b_d, rp_b_q, rp_b_d;
    logic [AW:0] occ_a_q, occ_a_d, occ_b_q, occ_b_d;
    logic [DATA_W-1:0] pa_q, pa_d, pb_q, pb_d;
    logic pv_q, pv_d, ovf_a_q, ovf_a_d, ovf_b_q, ovf_b_d, serr_q, serr_d;
    logic [SW-1:0] skew_q, diff, adiff;
    logic [31:0] cnt_q, cnt_d;
    logic flush, full_a, full_b, pop, wr_a, wr_b, skew_bad;
    always_comb begin
        flush    = state_q == FLUSH;
        full_a   = occ_a_q == (AW+1)'(DEPTH);
        full_b   = occ_b_q == (AW+1)'(DEPTH);
        // Both queues pop together so the pair index stays locked across channels.
        pop      = !flush && (!pv_q || pair_ready) && occ_a_q != '0 && occ_b_q != '0;
        wr_a     = !flush && data_in_A_channel_en && (!full_a || pop);
        wr_b     = !flush && data_in_B_channel_en && (!full_b || pop);
        diff     = SW'(occ_a_q) - SW'(occ_b_q);
        adiff    = diff[SW-1] ? -diff : diff;
        skew_bad = adiff > SW'(MAX_SKEW);
        wp_a_d   = flush ? '0 : wp_a_q + AW'(wr_a);
        wp_b_d   = flush ? '0 : wp_b_q + AW'(wr_b);
        rp_a_d   = flush ? '0 : rp_a_q + AW'(pop);
        rp_b_d   = flush ? '0 : rp_b_q + AW'(pop);
        occ_a_d  = flush ? '0 : occ_a_q + (AW+1)'(wr_a) - (AW+1)'(pop);
        occ_b_d  = flush ? '0 : occ_b_q + (AW+1)'(wr_b) - (AW+1)'(pop);
        state_d  = !flush && (resync_req || (AUTO_RESYNC && skew_bad)) ? FLUSH : RUN;
        ovf_a_d  = (!flush && data_in_A_channel_en && full_a && !pop) || (ovf_a_q && !clr_status);
        ovf_b_d  = (!flush && data_in_B_channel_en && full_b && !pop) || (ovf_b_q && !clr_status);
        serr_d   = skew_bad || (serr_q && !clr_status);
        pv_d     = flush ? 1'b0 : pop ? 1'b1 : pv_q && !pair_ready;
        pa_d     = pop ? mem_a_q[rp_a_q] : pa_q;
        pb_d     = pop ? mem_b_q[rp_b_q] : pb_q;
        cnt_d    = cnt_q + 32'(pv_q && pair_ready);
    end
    always_ff @(posedge alg_clk) begin
        if (wr_a) mem_a_q[wp_a_q] <= data_in_A_channel;
        if (wr_b) mem_b_q[wp_b_q] <= data_in_B_channel;
    end
    always_ff @(posedge alg_clk) begin
        if (alg_rst) begin
            state_q <= RUN;
            wp_a_q  <= '0;
            rp_a_q  <= '0;
            wp_b_q  <= '0;
            rp_b_q  <= '0;
            occ_a_q <= '0;
            occ_b_q <= '0;
            pa_q    <= '0;
            pb_q    <= '0;
            pv_q    <= 1'b0;
            ovf_a_q <= 1'b0;
            ovf_b_q <= 1'b0;
            serr_q  <= 1'b0;
            skew_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wp_a_q  <= wp_a_d;
            rp_a_q  <= rp_a_d;
            wp_b_q  <= wp_b_d;
            rp_b_q  <= rp_b_d;
            occ_a_q <= occ_a_d;
            occ_b_q <= occ_b_d;
            pa_q    <= pa_d;
            pb_q    <= pb_d;
            pv_q    <= pv_d;
            ovf_a_q <= ovf_a_d;
            ovf_b_q <= ovf_b_d;
            serr_q  <= serr_d;
            skew_q  <= diff;
            cnt_q   <= cnt_d;
        end
    end
    assign pair_A     = pa_q;
    assign pair_B     = pb_q;
    assign pair_valid = pv_q;
    assign overflow_A = ovf_a_q;
    assign overflow_B = ovf_b_q;
    assign skew_err   = serr_q;
    assign skew       = skew_q;
    assign pair_count = cnt_q;
endmodule

// File: tb/tb_adc_pair_realign.sv
// tb_adc_pair_realign: directed stimulus with hand-computed expectations for adc_pair_realign
// (DATA_W=16, DEPTH=8, MAX_SKEW=4, AUTO_RESYNC=1).
module tb_adc_pair_realign;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] a_d = '0, b_d = '0;
    logic a_en = 1'b0, b_en = 1'b0, resync = 1'b0, clr = 1'b0, ready = 1'b0;
    logic [15:0] pair_A, pair_B;
    logic pair_valid, overflow_A, overflow_B, skew_err;
    logic signed [4:0] skew;
    logic [31:0] pair_count;
    logic [31:0] exp_q [$];
    int n_assert = 0;
    int n_fail = 0;
    int peak;

    adc_pair_realign dut (
        .alg_clk(clk), .alg_rst(rst),
        .data_in_A_channel(a_d), .data_in_A_channel_en(a_en),
        .data_in_B_channel(b_d), .data_in_B_channel_en(b_en),
        .resync_req(resync), .clr_status(clr), .pair_ready(ready),
        .pair_A(pair_A), .pair_B(pair_B), .pair_valid(pair_valid),
        .overflow_A(overflow_A), .overflow_B(overflow_B), .skew_err(skew_err),
        .skew(skew), .pair_count(pair_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle; a pair presented with ready high is consumed at the coming edge.
    task automatic step(input logic ae, input logic [15:0] ad, input logic be, input logic [15:0] bd, input logic rdy);
        a_en = ae; a_d = ad; b_en = be; b_d = bd; ready = rdy;
        if (pair_valid === 1'b1 && rdy) begin
            if (exp_q.size() == 0) chk("unexpected_pair", {pair_A, pair_B}, 64'hFFFF_FFFF_FFFF);
            else chk("pair", {pair_A, pair_B}, exp_q.pop_front());
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) step(0, 16'h0, 0, 16'h0, rdy);
    endtask

    initial begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_valid", pair_valid, 0);
        chk("rst_pair", {pair_A, pair_B}, 0);
        chk("rst_flags", {overflow_A, overflow_B, skew_err}, 0);
        chk("rst_skew", skew, 0);
        chk("rst_count", pair_count, 0);

        // Aligned stream
        for (int i = 1; i <= 16; i++) begin
            exp_q.push_back({16'(i), 16'(16'h1000 + i)});
            step(1, 16'(i), 1, 16'(16'h1000 + i), 1);
            if (i == 1) chk("latency_e1", pair_valid, 0);
            if (i == 2) chk("latency_e2", pair_valid, 1);
        end
        idle(1, 3);
        chk("aligned_left", exp_q.size(), 0);
        chk("aligned_count", pair_count, 16);
        chk("aligned_flags", {overflow_A, overflow_B, skew_err}, 0);

        // Offset arrival: B three cycles behind A
        peak = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back({16'(16'h2000 + i), 16'(16'h3000 + i)});
        for (int s = 0; s < 12; s++) begin
            step(s < 8, 16'(16'h2000 + s), s >= 3 && s < 11, 16'(16'h3000 + s - 3), 1);
            if (int'(skew) > peak) peak = int'(skew);
        end
        idle(1, 3);
        chk("offset_peak", peak, 3);
        chk("offset_left", exp_q.size(), 0);
        chk("offset_skew_err", skew_err, 0);
        chk("offset_count", pair_count, 24);

        // Backpressure: 12 cycles stalled, queues overflow after 8 entries
        for (int s = 0; s < 12; s++) begin
            step(1, 16'(16'h4000 + s), 1, 16'(16'h5000 + s), 0);
            if (s == 5) chk("bp_hold_mid", {pair_valid, pair_A, pair_B}, {1'b1, 32'h4000_5000});
        end
        chk("bp_hold_end", {pair_valid, pair_A, pair_B}, {1'b1, 32'h4000_5000});
        chk("bp_overflow", {overflow_A, overflow_B}, 2'b11);
        for (int i = 0; i <= 8; i++) exp_q.push_back({16'(16'h4000 + i), 16'(16'h5000 + i)});
        for (int j = 0; j < 9; j++) begin
            chk("bp_no_gap", pair_valid, 1);
            step(0, 16'h0, 0, 16'h0, 1);
        end
        chk("bp_drained", pair_valid, 0);
        chk("bp_left", exp_q.size(), 0);
        chk("bp_count", pair_count, 33);
        clr = 1'b1;
        idle(1, 1);
        clr = 1'b0;
        chk("clr_overflow", {overflow_A, overflow_B}, 0);

        // Skew violation triggers an automatic flush
        for (int s = 0; s < 5; s++) step(1, 16'(16'h6000 + s), 0, 16'h0, 1);
        chk("skew_pre", skew_err, 0);
        idle(1, 1);
        chk("skew_err_set", skew_err, 1);
        chk("skew_value", skew, 5);
        step(1, 16'hDEAD, 1, 16'hBEEF, 1);
        chk("flush_no_ovf", {overflow_A, overflow_B}, 0);
        idle(1, 1);
        chk("flush_skew_zero", skew, 0);
        chk("skew_err_sticky", skew_err, 1);
        exp_q.push_back(32'h7001_8001);
        step(1, 16'h7001, 1, 16'h8001, 1);
        idle(1, 2);
        chk("resync_left", exp_q.size(), 0);
        chk("resync_count", pair_count, 34);

        // Manual resync discards a lone A sample
        step(1, 16'h9999, 0, 16'h0, 1);
        resync = 1'b1;
        idle(1, 1);
        resync = 1'b0;
        idle(1, 1);
        exp_q.push_back(32'hA001_B001);
        step(1, 16'hA001, 1, 16'hB001, 1);
        idle(1, 3);
        chk("manual_left", exp_q.size(), 0);
        chk("manual_count", pair_count, 35);
        clr = 1'b1;
        idle(1, 1);
        clr = 1'b0;
        chk("clr_skew_err", skew_err, 0);

        // Full queue with simultaneous pop accepts the write
        for (int s = 0; s < 9; s++) step(1, 16'(16'hC000 + s), 1, 16'(16'hD000 + s), 0);
        for (int i = 0; i <= 9; i++) exp_q.push_back({16'(16'hC000 + i), 16'(16'hD000 + i)});
        step(1, 16'hC009, 1, 16'hD009, 1);
        chk("full_pop_ovf", {overflow_A, overflow_B}, 0);
        idle(1, 10);
        chk("full_pop_left", exp_q.size(), 0);
        chk("full_pop_count", pair_count, 45);

        // Reset mid-operation with a held pair and set flags
        for (int s = 0; s < 10; s++) step(1, 16'(16'hE000 + s), 1, 16'(16'hF000 + s), 0);
        chk("pre_rst_state", {pair_valid, overflow_A, overflow_B}, 3'b111);
        rst = 1'b1;
        idle(0, 1);
        rst = 1'b0;
        chk("mid_rst_valid", pair_valid, 0);
        chk("mid_rst_pair", {pair_A, pair_B}, 0);
        chk("mid_rst_flags", {overflow_A, overflow_B, skew_err}, 0);
        chk("mid_rst_count", pair_count, 0);
        chk("mid_rst_skew", skew, 0);

        // clr_status coinciding with a new overflow: set wins
        for (int s = 0; s < 10; s++) step(1, 16'(s), 1, 16'(s), 0);
        chk("ovf_again", {overflow_A, overflow_B}, 2'b11);
        clr = 1'b1;
        step(1, 16'h55, 1, 16'h66, 0);
        chk("clr_vs_set", {overflow_A, overflow_B}, 2'b11);
        idle(0, 1);
        clr = 1'b0;
        chk("clr_after", {overflow_A, overflow_B}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
